relu_act_pipe: RTL and testbench
================================

// Module: relu_act_pipe
// PURPOSE
//  Parametrised successor to the single-lane ReLU stage: a LANES-wide signed activation unit between the
//  MAC/accumulator array and the output buffer. Per beat: bypass, ReLU, leaky ReLU (arith shift) or clipped
//  ReLU, through a 2-stage valid/ready pipeline with full backpressure. Counts zero-valued output lanes
//  (sparsity statistic) for the host.
// PARAMETERS
//  DATA_W      16  lane width, two's-complement signed
//  LANES       4   lanes per beat; data buses are LANES*DATA_W, lane i = bits [i*DATA_W +: DATA_W]
//  LEAK_SHIFT  3   leaky-ReLU negative slope = 2^-LEAK_SHIFT (1..DATA_W-1)
//  CNT_W       24  width of zero-lane counter
// PORTS
//  CLKEXT      in   1              single clock, all logic rising-edge
//  reset_n     in   1              asynchronous, active-low reset
//  cfg_mode    in   2              0=bypass 1=ReLU 2=leaky 3=clip; sampled with each accepted beat
//  cfg_clip    in   DATA_W         clip ceiling for mode 3 (signed; negative value acts as 0)
//  in_valid    in   1              input beat valid
//  in_ready    out  1              unit can accept a beat this cycle
//  in_data     in   LANES*DATA_W   input lanes
//  out_valid   out  1              output beat valid
//  out_ready   in   1              downstream accepts output
//  out_data    out  LANES*DATA_W   activated lanes
//  cnt_clr     in   1              synchronous clear of zero_cnt
//  zero_cnt    out  CNT_W          saturating count of zero output lanes delivered
// BEHAVIOUR
//  Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, zero_cnt=0,
//   stage data/mode regs=0. Reset mid-stream drops all in-flight beats; no partial beat survives.
//  Pipeline: S1 registers in_data + cfg_mode; S2 registers the activated result (= out_data).
//   adv2 = !s2_valid | out_ready;  adv1 = !s1_valid | adv2;  in_ready = adv1 (combinational, no in_valid dep).
//   Accept on in_valid&in_ready. Latency 2 cycles accept->out_valid when unstalled; throughput 1 beat/cycle.
//   Bubbles collapse: an empty stage fills even while downstream is stalled.
//   While out_valid & !out_ready: out_data, out_valid held stable (AXI-style); no beat dropped or duplicated.
//   out_valid never deasserts without a handshake.
//  Per-lane function, x = signed lane, result DATA_W signed:
//   mode0: y = x
//   mode1: y = (x<0) ? 0 : x
//   mode2: y = (x<0) ? (x >>> LEAK_SHIFT) : x   (arith shift, rounds toward -inf; -1 stays -1)
//   mode3: c = (cfg_clip<0) ? 0 : cfg_clip;  y = (x<0) ? 0 : (x>c ? c : x)
//   cfg_clip sampled into S1 together with cfg_mode; later cfg changes never affect in-flight beats.
//  zero_cnt: on out_valid&out_ready, add number of lanes with y==0 (0..LANES); saturates at 2^CNT_W-1.
//   cnt_clr alone -> 0 next cycle. cnt_clr with handshake same cycle -> load that beat's zero-lane count.
//  No overflow possible in datapath: all modes map into [min(x>>>LEAK_SHIFT), max(x)] of DATA_W.
// TESTING (DATA_W=16, LANES=4, LEAK_SHIFT=3)
//  Mode1, in lanes {0x8000,0xFFFF,0x0000,0x7FFF}, out_ready=1 -> 2 cycles later {0,0,0,0x7FFF}, zero_cnt=3.
//  Mode2, lanes {-8,-1,-17,100} -> {-1,-1,-3,100}; mode0 same input -> exact copy, zero_cnt unchanged.
//  Mode3 cfg_clip=50, lanes {-5,49,50,51} -> {0,49,50,50}; cfg_clip=-1, lanes {10,..} -> all 0.
//  Stream 8 beats, out_ready low 3 cycles mid-stream -> in_ready low after pipe full, out_data stable
//   while stalled, all 8 beats delivered in order, none lost/duplicated.
//  Change cfg_mode 1->0 the cycle after accepting a beat with negative lanes -> that beat still ReLU'd.
//  Assert reset_n low with 2 beats in flight -> out_valid=0, zero_cnt=0 immediately (async);
//   cnt_clr coincident with 4-zero-lane handshake -> zero_cnt=4; counter preloaded near max -> saturates.

Source files
------------

// File: rtl/relu_act_pipe.sv
// LANES-wide signed activation unit (bypass / ReLU / leaky ReLU / clipped ReLU)
// behind a two-stage valid/ready pipeline, with a saturating zero-lane counter.
module relu_act_pipe #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CNT_W      = 24
) (
  input  logic                      CLKEXT,
  input  logic                      reset_n,
  input  logic [1:0]                cfg_mode,
  input  logic [DATA_W-1:0]         cfg_clip,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          zero_cnt
);

  localparam int unsigned ZW = $clog2(LANES + 1);
  localparam int unsigned SW = CNT_W + 1;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLIP   = 2'd3
  } mode_t;

  logic                      s1_valid;
  logic [LANES*DATA_W-1:0]   s1_data;
  mode_t                     s1_mode;
  logic [DATA_W-1:0]         s1_clip;
  logic                      s2_valid;
  logic [LANES*DATA_W-1:0]   s2_data;

  logic                      adv1;
  logic                      adv2;
  logic                      hs;
  logic [LANES*DATA_W-1:0]   act;
  logic signed [DATA_W-1:0]  x;
  logic signed [DATA_W-1:0]  y;
  logic signed [DATA_W-1:0]  c;
  logic [ZW-1:0]             zeros;
  logic [SW-1:0]             sum;

  // A stage may load whenever it is empty or its contents move on this cycle.
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign hs        = s2_valid && out_ready;

  always_ff @(posedge CLKEXT or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_BYPASS;
      s1_clip  <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= mode_t'(cfg_mode);
        s1_clip <= cfg_clip;
      end
    end
  end

  always_comb begin
    act = '0;
    x   = '0;
    y   = '0;
    c   = s1_clip[DATA_W-1] ? '0 : s1_clip;
    for (int unsigned i = 0; i < LANES; i++) begin
      x = s1_data[i*DATA_W +: DATA_W];
      unique case (s1_mode)
        MODE_BYPASS: y = x;
        MODE_RELU:   y = x[DATA_W-1] ? '0 : x;
        MODE_LEAKY:  y = x[DATA_W-1] ? (x >>> LEAK_SHIFT) : x;
        MODE_CLIP:   y = x[DATA_W-1] ? '0 : ((x > c) ? c : x);
      endcase
      act[i*DATA_W +: DATA_W] = y;
    end
  end

  always_ff @(posedge CLKEXT or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= act;
      end
    end
  end

  always_comb begin
    zeros = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (s2_data[i*DATA_W +: DATA_W] == '0) begin
        zeros = zeros + ZW'(1);
      end
    end
    sum = {1'b0, zero_cnt} + SW'(zeros);
  end

  // Clear wins over accumulation, but a beat delivered in the clear cycle still counts.
  always_ff @(posedge CLKEXT or negedge reset_n) begin
    if (!reset_n) begin
      zero_cnt <= '0;
    end else if (cnt_clr) begin
      zero_cnt <= hs ? CNT_W'(zeros) : '0;
    end else if (hs) begin
      zero_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_relu_act_pipe.sv
// Scoreboard bench for relu_act_pipe: stimulus pushes reference-model beats,
// an independent monitor pops and compares on every output handshake.
module tb_relu_act_pipe;

  localparam int DW   = 16;
  localparam int L    = 4;
  localparam int LS   = 3;
  localparam longint CNT_MAX = (longint'(1) << 24) - 1;
  localparam longint SAT_MAX = 15;

  logic          CLKEXT = 1'b0;
  logic          reset_n;
  logic [1:0]    cfg_mode;
  logic [15:0]   cfg_clip;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic          cnt_clr;
  logic [23:0]   zero_cnt;

  logic          sat_in_ready;
  logic          sat_out_valid;
  logic [63:0]   sat_out_data;
  logic [3:0]    sat_zero_cnt;

  relu_act_pipe #(.DATA_W(16), .LANES(4), .LEAK_SHIFT(3), .CNT_W(24)) dut (
    .CLKEXT(CLKEXT), .reset_n(reset_n), .cfg_mode(cfg_mode), .cfg_clip(cfg_clip),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_clr(cnt_clr), .zero_cnt(zero_cnt));

  relu_act_pipe #(.DATA_W(16), .LANES(4), .LEAK_SHIFT(3), .CNT_W(4)) dut_sat (
    .CLKEXT(CLKEXT), .reset_n(reset_n), .cfg_mode(cfg_mode), .cfg_clip(cfg_clip),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .cnt_clr(cnt_clr), .zero_cnt(sat_zero_cnt));

  always #5 CLKEXT = ~CLKEXT;

  int cyc = 0;
  always @(posedge CLKEXT) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          acc;
    bit          lat;
  } item_t;

  item_t  q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  bit     accepted;
  bit     lat_flag = 1'b0;
  bit     rand_bp  = 1'b0;
  bit     rand_clr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: lane rules in plain integer arithmetic.
  function automatic logic [63:0] ref_beat(input logic [63:0] d, input int mode, input int clip);
    logic [63:0] r;
    int x, y, c, qt;
    r = '0;
    for (int i = 0; i < L; i++) begin
      x = int'($signed(d[i*DW +: DW]));
      case (mode)
        0: y = x;
        1: y = (x < 0) ? 0 : x;
        2: begin
          if (x < 0) begin
            qt = x / (1 << LS);
            if (qt * (1 << LS) != x) qt = qt - 1;
            y = qt;
          end else y = x;
        end
        default: begin
          c = (clip < 0) ? 0 : clip;
          y = (x < 0) ? 0 : ((x > c) ? c : x);
        end
      endcase
      r[i*DW +: DW] = y[15:0];
    end
    return r;
  endfunction

  function automatic int zeros_of(input logic [63:0] d);
    int z = 0;
    for (int i = 0; i < L; i++) if (d[i*DW +: DW] == 16'h0) z++;
    return z;
  endfunction

  function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [15:0] b0, b1, b2, b3;
    b0 = a0[15:0]; b1 = a1[15:0]; b2 = a2[15:0]; b3 = a3[15:0];
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [15:0] rnd_lane();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      4: return 16'($urandom_range(0, 7)) - 16'd4;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic step();
    item_t it;
    @(negedge CLKEXT);
    accepted = 1'b0;
    if (reset_n && in_valid && in_ready) begin
      it.data = ref_beat(in_data, int'(cfg_mode), int'($signed(cfg_clip)));
      it.acc  = cyc;
      it.lat  = lat_flag;
      q.push_back(it);
      accepted = 1'b1;
    end
    @(posedge CLKEXT);
    #1;
    if (rand_bp)  out_ready = ($urandom_range(0, 3) != 0);
    if (rand_clr) cnt_clr   = ($urandom_range(0, 15) == 0);
  endtask

  task automatic send(input int mode, input logic [15:0] clip, input logic [63:0] d, input bit lat);
    int n = 0;
    cfg_mode = 2'(mode);
    cfg_clip = clip;
    in_data  = d;
    in_valid = 1'b1;
    lat_flag = lat;
    do begin
      step();
      n++;
    end while (!accepted && n < 100);
    chk("accept", {63'd0, accepted}, 64'd1);
    lat_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Monitor: scoreboard pop, hold-while-stalled, and zero-counter model.
  longint      m_cnt = 0;
  longint      m_sat = 0;
  bit          stall_prev = 1'b0;
  logic [63:0] prev_data;

  always @(negedge CLKEXT) begin
    item_t it;
    bit    hs;
    int    z;
    if (!reset_n) begin
      q.delete();
      m_cnt = 0;
      m_sat = 0;
      stall_prev = 1'b0;
    end else begin
      chk("zero_cnt", {40'd0, zero_cnt}, 64'(m_cnt));
      chk("zero_cnt_sat", {60'd0, sat_zero_cnt}, 64'(m_sat));
      if (stall_prev) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", out_data, prev_data);
      end
      hs = out_valid && out_ready;
      z  = 0;
      if (hs) begin
        if (q.size() == 0) begin
          chk("spurious_beat", {63'd0, out_valid}, 64'd0);
        end else begin
          it = q.pop_front();
          chk("out_data", out_data, it.data);
          if (it.lat) chk("latency", 64'(cyc - it.acc), 64'd2);
          z = zeros_of(it.data);
        end
      end
      if (cnt_clr) begin
        m_cnt = hs ? z : 0;
        m_sat = hs ? z : 0;
      end else if (hs) begin
        m_cnt = (m_cnt + z > CNT_MAX) ? CNT_MAX : m_cnt + z;
        m_sat = (m_sat + z > SAT_MAX) ? SAT_MAX : m_sat + z;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    logic [63:0] beats[8];
    int w;

    reset_n   = 1'b0;
    cfg_mode  = 2'd0;
    cfg_clip  = 16'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    repeat (3) @(posedge CLKEXT);
    @(negedge CLKEXT);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_zero_cnt", {40'd0, zero_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge CLKEXT);
    #1 reset_n = 1'b1;
    idle(2);

    // ReLU boundary lanes, latency from an empty pipe
    send(1, 16'd0, pack4(-32768, -1, 0, 32767), 1'b1);
    idle(3);
    chk("relu_zero_cnt", {40'd0, zero_cnt}, 64'd3);

    // Leaky and bypass on the same lanes
    send(2, 16'd0, pack4(-8, -1, -17, 100), 1'b0);
    send(0, 16'd0, pack4(-8, -1, -17, 100), 1'b0);
    idle(3);

    // Clip with positive and negative ceiling
    send(3, 16'd50, pack4(-5, 49, 50, 51), 1'b0);
    send(3, 16'hFFFF, pack4(10, 20, 30, 40), 1'b0);
    idle(3);

    // Config change right after acceptance must not touch the in-flight beat
    send(1, 16'd0, pack4(-3, -100, 5, -1), 1'b0);
    send(0, 16'd0, pack4(-3, -100, 5, -1), 1'b0);
    idle(3);

    // 8-beat stream with a 3-cycle downstream stall
    for (int i = 0; i < 8; i++)
      beats[i] = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
    for (int i = 0; i < 4; i++) send(2, 16'd0, beats[i], 1'b0);
    out_ready = 1'b0;
    cfg_mode  = 2'd2;
    in_data   = beats[4];
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge CLKEXT);
      chk("in_ready_stalled", {63'd0, in_ready}, 64'd0);
      @(posedge CLKEXT);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) send(2, 16'd0, beats[i], 1'b0);
    idle(4);

    // Clear coinciding with a four-zero-lane handshake
    send(1, 16'd0, pack4(-1, -2, -3, -4), 1'b0);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    step();
    step();
    cnt_clr = 1'b0;
    chk("clr_load", {40'd0, zero_cnt}, 64'd4);
    idle(2);

    // Asynchronous reset with two beats in flight
    send(1, 16'd0, pack4(-1, 0, 3, 4), 1'b0);
    send(1, 16'd0, pack4(-9, 0, 0, 4), 1'b0);
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_zero_cnt", {40'd0, zero_cnt}, 64'd0);
    chk("async_sat_cnt", {60'd0, sat_zero_cnt}, 64'd0);
    repeat (2) @(posedge CLKEXT);
    #1 reset_n = 1'b1;
    idle(4);

    // Randomised traffic with backpressure and sporadic clears
    rand_bp  = 1'b1;
    rand_clr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 200)),
           {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()}, 1'b0);
    end
    rand_bp   = 1'b0;
    rand_clr  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    in_valid  = 1'b0;
    w = 0;
    while (q.size() != 0 && w < 50) begin
      step();
      w++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
